// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, reset PC
// and the alignment helper. The optional alignment check is enabled with the
// FETCH_ALIGN_CHECK_EN macro.
package fetch_seq_pkg;

    // 2-bit fetch FSM encodings; S_HALT is only reachable with the alignment check.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_INC   = 32'd4;

    // True when an address is not word aligned.
    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_seq_redirect_buf.sv
// Pending redirect target register plus the next-PC priority select:
// a same-cycle redirect beats a pending one, which beats sequential fetch.
module fetch_seq_redirect_buf
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] PC_STEP = PC_INC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        consume,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pend_valid
);

    logic [31:0] pend_target;

    // Capture a redirect that arrives outside an ack cycle; the ack consumes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (consume) begin
            pend_valid <= 1'b0;
        end else if (redirect_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= redirect_target;
        end
    end

    // Next PC priority: live redirect, then pending target, then pc + step (mod 2^32).
    always_comb begin
        next_pc = pc + PC_STEP;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake and presents
// each fetched word to ID. Handshakes: imem_req stays high with imem_addr
// stable until a cycle with imem_ack, when imem_rdata is taken; if_valid
// stays high with if_instr/if_pc stable until a cycle with id_ready, which is
// the transfer. Optional alignment check: FETCH_ALIGN_CHECK_EN.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET,
    parameter logic [31:0] PC_STEP  = PC_INC
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    input  logic         id_ready,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    output fetch_state_t state
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic         fetch_adel
`endif
);

    fetch_state_t cur_state;
    fetch_state_t next_state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         pend_valid;
    logic         ack_take;

    assign ack_take  = (cur_state == S_REQ) && imem_ack;
    assign imem_addr = pc;
    assign state     = cur_state;

    fetch_seq_redirect_buf #(
        .PC_STEP(PC_STEP)
    ) u_redirect_buf (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .consume        (ack_take),
        .pc             (pc),
        .next_pc        (next_pc),
        .pend_valid     (pend_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = cur_state;
        imem_req   = 1'b0;
        if_valid   = 1'b0;
        case (cur_state)
            S_IDLE: next_state = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if_valid = 1'b1;
                if (id_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    next_state = misaligned(pc) ? S_HALT : S_REQ;
`else
                    next_state = S_REQ;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_HALT: next_state = S_HALT;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // PC and IF/ID output registers, updated only on the ack edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
        end else if (ack_take) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            pc       <= next_pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky address-error flag raised when a misaligned next PC is selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_adel <= 1'b0;
        end else if (ack_take && misaligned(next_pc)) begin
            fetch_adel <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    logic         clk;
    logic         reset;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         if_valid;
    logic [31:0]  if_instr;
    logic [31:0]  if_pc;
    logic         id_ready;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    fetch_state_t state;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fetch_adel;
`endif

    int checks = 0;
    int errors = 0;

    fetch_seq dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .state          (state)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_adel     (fetch_adel)
`endif
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the imem side and the IF/ID side together.
    task automatic expect_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_ifv"}, {31'b0, if_valid}, 32'd0);
    endtask

    task automatic expect_hold(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] addr);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_ifv"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_ifpc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, instr);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0000_3000);
        check({tag, "_ifv"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_ifpc"}, if_pc, 32'h0);
        check({tag, "_instr"}, if_instr, 32'h0);
        check({tag, "_state"}, {30'b0, state}, {30'b0, S_IDLE});
    endtask

    initial begin
        reset           = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset state.
        step();
        step();
        expect_reset("rst");

        // Release: one S_IDLE cycle, then S_REQ.
        reset = 1'b1;
        check("idle_state", {30'b0, state}, {30'b0, S_IDLE});
        step();
        check("req_state", {30'b0, state}, {30'b0, S_REQ});

        // Zero-wait memory, ID always ready.
        imem_ack = 1'b1;
        id_ready = 1'b1;
        expect_req("zw0", 32'h0000_3000);
        imem_rdata = 32'h1111_0000;
        step();
        expect_hold("zw0h", 32'h0000_3000, 32'h1111_0000, 32'h0000_3004);
        step();
        expect_req("zw1", 32'h0000_3004);
        imem_rdata = 32'h1111_0004;
        step();
        expect_hold("zw1h", 32'h0000_3004, 32'h1111_0004, 32'h0000_3008);
        step();
        expect_req("zw2", 32'h0000_3008);
        imem_rdata = 32'h1111_0008;
        id_ready = 1'b0;
        step();

        // ID stalls for 5 cycles: held word stays put, no request.
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            expect_hold("stall", 32'h0000_3008, 32'h1111_0008, 32'h0000_300C);
            step();
        end
        expect_hold("stall_end", 32'h0000_3008, 32'h1111_0008, 32'h0000_300C);
        id_ready = 1'b1;
        step();

        // Memory acks 3 cycles late.
        for (int i = 0; i < 3; i++) begin
            expect_req("late", 32'h0000_300C);
            check("late_instr", if_instr, 32'h1111_0008);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_000C;
        expect_req("late_ack", 32'h0000_300C);
        id_ready = 1'b0;
        step();
        expect_hold("late_h", 32'h0000_300C, 32'h1111_000C, 32'h0000_3010);

        // Redirect while holding 300C: 3010 is the delay slot, then 3100.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3100;
        step();
        redirect_valid = 1'b0;
        expect_hold("rd_h", 32'h0000_300C, 32'h1111_000C, 32'h0000_3010);
        id_ready = 1'b1;
        step();
        expect_req("rd_slot", 32'h0000_3010);
        imem_rdata = 32'h1111_0010;
        step();
        expect_hold("rd_slot_h", 32'h0000_3010, 32'h1111_0010, 32'h0000_3100);
        step();
        expect_req("rd_tgt", 32'h0000_3100);

        // Redirect in the ack cycle: takes effect immediately.
        imem_rdata      = 32'h1111_3100;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3200;
        step();
        redirect_valid = 1'b0;
        expect_hold("rd_ack_h", 32'h0000_3100, 32'h1111_3100, 32'h0000_3200);
        step();
        expect_req("rd_ack", 32'h0000_3200);

        // Pending target from a non-ack cycle loses to a live redirect at ack.
        imem_ack        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_4000;
        step();
        expect_req("stale_wait", 32'h0000_3200);
        imem_ack        = 1'b1;
        imem_rdata      = 32'h1111_3200;
        redirect_target = 32'h0000_3300;
        step();
        redirect_valid = 1'b0;
        expect_hold("stale_h", 32'h0000_3200, 32'h1111_3200, 32'h0000_3300);
        step();
        expect_req("stale_tgt", 32'h0000_3300);
        imem_rdata = 32'h1111_3300;
        step();
        expect_hold("stale_clr", 32'h0000_3300, 32'h1111_3300, 32'h0000_3304);
        step();
        expect_req("seq_after", 32'h0000_3304);

        // Reset mid-request: outputs return to reset values asynchronously.
        imem_ack = 1'b0;
        step();
        expect_req("pre_rst", 32'h0000_3304);
        reset = 1'b0;
        #1;
        expect_reset("async_rst");
        step();
        reset = 1'b1;
        step();
        expect_req("post_rst", 32'h0000_3000);

        // Wrap: redirect to FFFF_FFFC, next sequential PC is 0.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h2222_3000;
        step();
        expect_hold("wrap_slot", 32'h0000_3000, 32'h2222_3000, 32'hFFFF_FFFC);
        step();
        expect_req("wrap_top", 32'hFFFF_FFFC);
        imem_rdata = 32'h2222_FFFC;
        step();
        expect_hold("wrap_h", 32'hFFFF_FFFC, 32'h2222_FFFC, 32'h0000_0000);
        step();
        expect_req("wrap_zero", 32'h0000_0000);

        // Misaligned redirect target.
        imem_rdata      = 32'h2222_0000;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3002;
        step();
        redirect_valid = 1'b0;
        expect_hold("mis_h", 32'h0000_0000, 32'h2222_0000, 32'h0000_3002);
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_adel", {31'b0, fetch_adel}, 32'd1);
        check("mis_halt", {30'b0, state}, {30'b0, S_HALT});
        check("mis_req", {31'b0, imem_req}, 32'd0);
`else
        expect_req("mis_issue", 32'h0000_3002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
